// File: rtl/bcd_two_digit_adder.sv
// Registered packed-BCD adder: ripple of decimal digit stages, one-cycle
// latency, valid-qualified result and a flag for non-BCD input digits.
module bcd_two_digit_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         cout,
    output logic         out_valid,
    output logic         bcd_err
);

    localparam int D = N / 4;

    // Widths that are not a whole number of digits make no sense for BCD.
    if (N <= 0 || (N % 4) != 0) begin : g_bad_width
        $error("bcd_two_digit_adder: N must be a positive multiple of 4");
    end

    // One decimal digit: binary add, then add 6 to skip codes 10..15 when
    // the digit overflows. Returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       c);
        logic [4:0] t;
        logic [4:0] adj;
        t   = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        adj = t + 5'd6;
        if (t > 5'd9) begin
            bcd_digit = {1'b1, adj[3:0]};
        end else begin
            bcd_digit = {1'b0, t[3:0]};
        end
    endfunction

    // A digit value above 9 is not legal BCD.
    function automatic logic not_bcd(input logic [3:0] d);
        not_bcd = (d > 4'd9);
    endfunction

    logic [D:0]   carry;
    logic [N-1:0] sum;
    logic [D-1:0] err;

    assign carry[0] = cin;

    for (genvar i = 0; i < D; i++) begin : g_digit
        assign {carry[i+1], sum[4*i +: 4]} = bcd_digit(A[4*i +: 4], B[4*i +: 4], carry[i]);
        assign err[i] = not_bcd(A[4*i +: 4]) | not_bcd(B[4*i +: 4]);
    end

    // ---- stage p1: registered result ----
    logic [N-1:0] s_p1;
    logic         cout_p1;
    logic         err_p1;
    logic         vld_p1;

    // Capture a new result only on valid input; otherwise hold the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_p1    <= '0;
            cout_p1 <= 1'b0;
            err_p1  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                s_p1    <= sum;
                cout_p1 <= carry[D];
                err_p1  <= |err;
            end
        end
    end

    assign S         = s_p1;
    assign cout      = cout_p1;
    assign bcd_err   = err_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_bcd_two_digit_adder.sv
// Self-checking bench for bcd_two_digit_adder (N=8): directed cases,
// exhaustive decimal sweep and randomized traffic against a reference model.
module tb_bcd_two_digit_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       cin = 1'b0;
    logic [7:0] S;
    logic       cout;
    logic       out_valid;
    logic       bcd_err;

    int tests = 0;
    int fails = 0;

    bcd_two_digit_adder #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .S         (S),
        .cout      (cout),
        .out_valid (out_valid),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, sample just after the rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic c);
        @(negedge clk);
        rst = r; in_valid = v; A = a; B = b; cin = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int x);
        logic [7:0] r;
        r[7:4] = 4'(x / 10);
        r[3:0] = 4'(x % 10);
        return r;
    endfunction

    function automatic int bcd_val(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    // Reference for arbitrary nibbles: digit-by-digit decimal rule on integers.
    function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic c);
        int carry = int'(c);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 2; i++) begin
            int t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + carry;
            if (t > 9) begin
                s[4*i +: 4] = 4'((t + 6) % 16);
                carry = 1;
            end else begin
                s[4*i +: 4] = 4'(t);
                carry = 0;
            end
        end
        return {carry[0], s};
    endfunction

    function automatic logic has_err(input logic [7:0] a, input logic [7:0] b);
        return (a[3:0] > 9) || (a[7:4] > 9) || (b[3:0] > 9) || (b[7:4] > 9);
    endfunction

    initial begin
        logic [7:0] exp_s;
        logic       exp_c;
        logic       exp_e;
        logic [8:0] r;

        // Reset held two cycles while valid operands are presented.
        step(1'b1, 1'b1, 8'h99, 8'h99, 1'b1);
        step(1'b1, 1'b1, 8'h99, 8'h99, 1'b1);
        chk("rst_S", S, 8'h00);
        chk("rst_cout", cout, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_err", bcd_err, 0);

        // Single-digit carry, without and with carry-in.
        step(1'b0, 1'b1, 8'h07, 8'h08, 1'b0);
        chk("d1_S", S, 8'h15);
        chk("d1_cout", cout, 0);
        chk("d1_vld", out_valid, 1);
        chk("d1_err", bcd_err, 0);
        step(1'b0, 1'b1, 8'h07, 8'h08, 1'b1);
        chk("d1c_S", S, 8'h16);
        chk("d1c_cout", cout, 0);

        // Inter-digit carry.
        step(1'b0, 1'b1, 8'h29, 8'h17, 1'b0);
        chk("d2_S", S, 8'h46);
        chk("d2_cout", cout, 0);

        // Overflow cases.
        step(1'b0, 1'b1, 8'h50, 8'h50, 1'b0);
        chk("ov1_S", S, 8'h00);
        chk("ov1_cout", cout, 1);
        step(1'b0, 1'b1, 8'h99, 8'h99, 1'b1);
        chk("ov2_S", S, 8'h99);
        chk("ov2_cout", cout, 1);

        // Back-to-back results, then a hold cycle, then a non-BCD operand.
        step(1'b0, 1'b1, 8'h07, 8'h08, 1'b0);
        chk("b2b1_S", S, 8'h15);
        chk("b2b1_vld", out_valid, 1);
        step(1'b0, 1'b1, 8'h29, 8'h17, 1'b0);
        chk("b2b2_S", S, 8'h46);
        chk("b2b2_vld", out_valid, 1);
        step(1'b0, 1'b0, 8'h33, 8'h44, 1'b1);
        chk("hold_vld", out_valid, 0);
        chk("hold_S", S, 8'h46);
        chk("hold_cout", cout, 0);
        step(1'b0, 1'b1, 8'h0A, 8'h00, 1'b0);
        chk("err_S", S, 8'h10);
        chk("err_cout", cout, 0);
        chk("err_flag", bcd_err, 1);
        chk("err_vld", out_valid, 1);

        // Reset mid-stream discards the in-flight operation.
        step(1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_S", S, 8'h00);
        chk("mrst_err", bcd_err, 0);

        // Exhaustive decimal sweep against plain integer addition.
        for (int a = 0; a < 100; a++) begin
            for (int b = 0; b < 100; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int sum;
                    sum = a + b + c;
                    step(1'b0, 1'b1, to_bcd(a), to_bcd(b), c[0]);
                    chk("ex_S", S, to_bcd(sum % 100));
                    chk("ex_cout", cout, (sum >= 100) ? 1 : 0);
                    chk("ex_err", bcd_err, 0);
                end
            end
        end
        chk("ex_vld", out_valid, 1);
        exp_s = to_bcd((99 + 99 + 1) % 100);
        exp_c = 1'b1;
        exp_e = 1'b0;

        // Random traffic with arbitrary nibbles and gaps in in_valid.
        for (int n = 0; n < 600; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic       c;
            logic       v;
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if (n % 2 == 0 && !has_err(a, b)) begin
                // Keep a decimal cross-check on valid operands.
                int sum;
                sum = bcd_val(a) + bcd_val(b) + int'(c);
                r = {(sum >= 100) ? 1'b1 : 1'b0, to_bcd(sum % 100)};
            end else begin
                r = ref_add(a, b, c);
            end
            step(1'b0, v, a, b, c);
            if (v) begin
                exp_s = r[7:0];
                exp_c = r[8];
                exp_e = has_err(a, b);
            end
            chk("rnd_vld", out_valid, v);
            chk("rnd_S", S, exp_s);
            chk("rnd_cout", cout, exp_c);
            chk("rnd_err", bcd_err, exp_e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_two_digit_adder.md
Name: bcd_two_digit_adder

Overview:
- Registered, parameterised BCD adder: adds two packed-BCD operands plus a carry-in, producing a packed-BCD sum and a decimal carry-out.
- Default width N=8 gives two decimal digits (00..99).
- Used as a decimal arithmetic leaf inside datapaths. Single clock domain, one-cycle latency, valid-qualified output, flag for non-BCD input digits.

Parameters:
- N, 8, operand/sum width in bits. Must be a positive multiple of 4; digit count D = N/4; N=8 means two digits. Any other N is a configuration error that elaboration must reject.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands on A/B/cin are valid this cycle
- A  input  N  first operand, packed BCD, digit 0 in A[3:0]
- B  input  N  second operand, packed BCD
- cin  input  1  decimal carry-in into digit 0
- S  output  N  registered packed-BCD sum
- cout  output  1  registered decimal carry-out of the top digit
- out_valid  output  1  S/cout/bcd_err hold a result computed from an in_valid cycle
- bcd_err  output  1  registered flag: some digit of the sampled A or B was greater than 9

Behaviour:
- Reset: on a rising edge with rst=1, S=0, cout=0, out_valid=0, bcd_err=0. rst has priority over in_valid.
- Arithmetic is a ripple of D digit stages. For digit i:
  - t = A_i + B_i + c_i, a 5-bit value, with c_0 = cin.
  - If t > 9: S_i = (t + 6) mod 16 and c_{i+1} = 1.
  - Else: S_i = t and c_{i+1} = 0.
  - cout = c_D.
- Latency is 1 cycle. If in_valid=1 at edge k (rst=0), then after edge k, S/cout/bcd_err reflect that cycle's A/B/cin and out_valid=1.
- If in_valid=0 at an edge (rst=0): out_valid goes to 0, and S/cout/bcd_err hold their previous values.
- A full throughput of one addition per cycle is supported. There is no backpressure.
- bcd_err=1 when any nibble of A or B is in 10..15. The sum is still computed by the rule above with no saturation. Example: A=0x0A, B=0x00, cin=0 gives S=0x10, cout=0, bcd_err=1.
- With valid BCD inputs, the maximum case 99+99+1 gives S=0x99, cout=1. Every S digit is guaranteed to be in 0..9.
- Reset asserted mid-stream discards the in-flight result: out_valid=0 on the next cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and A=0x99 -> S=0x00, cout=0, out_valid=0, bcd_err=0.
- Single-digit carry: A=0x07, B=0x08, cin=0 -> next cycle S=0x15, cout=0, out_valid=1. Then cin=1 with the same operands -> S=0x16, cout=0.
- Inter-digit carry: A=0x29, B=0x17, cin=0 -> S=0x46, cout=0.
- Overflow: A=0x50, B=0x50, cin=0 -> S=0x00, cout=1. Also A=0x99, B=0x99, cin=1 -> S=0x99, cout=1.
- Back-to-back, hold and invalid inputs:
  - Apply (0x07,0x08,0) then (0x29,0x17,0) on consecutive cycles -> results appear on consecutive cycles.
  - Then drop in_valid -> out_valid=0 and S holds 0x46.
  - Then A=0x0A, B=0x00 -> S=0x10, bcd_err=1.
- Exhaustive: all A,B in 00..99 with cin in {0,1} -> S and cout match the decimal sum A+B+cin; bcd_err=0 throughout.
